// File: rtl/tug_of_war_referee.sv
// Referee for a nine-light tug-of-war game: gates player presses onto the
// playfield, scores edge hits, holds the field in reset between points.
module tug_of_war_referee #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic [8:0] lights,
  output logic       L_out,
  output logic       R_out,
  output logic       field_reset,
  output logic [2:0] L_score,
  output logic [2:0] R_score,
  output logic       game_over,
  output logic       winner,
  output logic       fault,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam logic [2:0] WIN  = 3'(WIN_SCORE);
  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] l_score_q, l_score_d;
  logic [2:0] r_score_q, r_score_d;
  logic       winner_q, winner_d;
  logic       fault_q, fault_d;

  logic       lights_onehot;
  logic       left_pt, right_pt;
  logic [2:0] l_next, r_next;

  // A press only scores when it alone arrives while the light sits on the edge.
  assign lights_onehot = (lights != 9'd0) && ((lights & (lights - 9'd1)) == 9'd0);
  assign left_pt  = (state_q == S_PLAY) && lights[8] && L && !R && (l_score_q < WIN);
  assign right_pt = (state_q == S_PLAY) && lights[0] && R && !L && (r_score_q < WIN);
  assign l_next   = l_score_q + 3'd1;
  assign r_next   = r_score_q + 3'd1;

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    hold_cnt_q <= hold_cnt_d;
    l_score_q  <= l_score_d;
    r_score_q  <= r_score_d;
    winner_q   <= winner_d;
    fault_q    <= fault_d;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    l_score_d  = l_score_q;
    r_score_d  = r_score_q;
    winner_d   = winner_q;
    fault_d    = fault_q;
    unique case (state_q)
      S_INIT: state_d = S_PLAY;
      S_PLAY: begin
        if (!lights_onehot) fault_d = 1'b1;
        if (left_pt) begin
          l_score_d = l_next;
          if (l_next == WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD;
          end
        end else if (right_pt) begin
          r_score_d = r_next;
          if (r_next == WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b1;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q <= 4'd1) begin
          state_d    = S_PLAY;
          hold_cnt_d = 4'd0;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      S_OVER: state_d = S_OVER;
      default: state_d = S_INIT;
    endcase
    // Reset overrides any point or hold countdown seen in the same cycle.
    if (reset) begin
      state_d    = S_INIT;
      hold_cnt_d = 4'd0;
      l_score_d  = 3'd0;
      r_score_d  = 3'd0;
      winner_d   = 1'b0;
      fault_d    = 1'b0;
    end
  end

  always_comb begin
    field_reset = 1'b1;
    L_out       = 1'b0;
    R_out       = 1'b0;
    if (!reset && state_q == S_PLAY) begin
      field_reset = 1'b0;
      L_out       = L & ~R;
      R_out       = R & ~L;
    end
  end

  assign L_score     = l_score_q;
  assign R_score     = r_score_q;
  assign game_over   = (state_q == S_OVER);
  assign winner      = winner_q;
  assign fault       = fault_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_tug_of_war_referee.sv
// Directed bench for tug_of_war_referee: a behavioural nine-light playfield
// feeds the referee; expected status words flow through exp_q.
module tb_tug_of_war_referee;

  localparam int WIN_SCORE   = 7;
  localparam int HOLD_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset, L, R;
  logic [8:0] lights;
  logic       L_out, R_out, field_reset, game_over, winner, fault;
  logic [2:0] L_score, R_score;
  logic [1:0] state_dbg;

  tug_of_war_referee #(.WIN_SCORE(WIN_SCORE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .lights(lights),
    .L_out(L_out), .R_out(R_out), .field_reset(field_reset),
    .L_score(L_score), .R_score(R_score), .game_over(game_over),
    .winner(winner), .fault(fault), .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // playfield model: one lit position, recentred whenever field_reset is high
  int         pos = 4;
  logic       force_en = 1'b0;
  logic [8:0] force_val = '0;

  always @(posedge clk) begin
    if (field_reset) pos <= 4;
    else if (L_out && pos < 8) pos <= pos + 1;
    else if (R_out && pos > 0) pos <= pos - 1;
  end

  always_comb begin
    lights = '0;
    lights[pos] = 1'b1;
    if (force_en) lights = force_val;
  end

  // scoreboard
  logic [9:0] exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [2:0] exp_l = 3'd0, exp_r = 3'd0;
  logic       exp_go = 1'b0, exp_w = 1'b0, exp_f = 1'b0;
  logic       cur_fr = 1'b1;

  function automatic logic [9:0] status_obs();
    return {field_reset, L_score, R_score, game_over, winner, fault};
  endfunction

  function automatic logic [9:0] status_exp(input logic fr);
    return {fr, exp_l, exp_r, exp_go, exp_w, exp_f};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // drivers: one clock edge per step; gated outputs checked before the edge,
  // status word checked after it
  task automatic step(input logic l, input logic r, input logic rst,
                      input logic nx_fr, input string tag);
    logic [9:0] want;
    logic       exp_lo, exp_ro;
    @(negedge clk);
    L = l; R = r; reset = rst;
    #1;
    exp_lo = l & ~r & ~rst & ~cur_fr;
    exp_ro = r & ~l & ~rst & ~cur_fr;
    chk({tag, ":L_out"}, {9'd0, L_out}, {9'd0, exp_lo});
    chk({tag, ":R_out"}, {9'd0, R_out}, {9'd0, exp_ro});
    exp_q.push_back(status_exp(nx_fr));
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    chk({tag, ":status"}, status_obs(), want);
    cur_fr = want[9];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic walk_left();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "walk_l");
    chk("lights_left_edge", lights, 10'(9'b100000000));
  endtask

  task automatic walk_right();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "walk_r");
    chk("lights_right_edge", lights, 10'(9'b000000001));
  endtask

  // remaining held cycles with random presses that must be dropped
  task automatic hold_phase();
    for (int k = 2; k <= HOLD_CYCLES; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, "hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold_exit");
    chk("lights_recentred", lights, 10'(9'b000010000));
  endtask

  task automatic left_point(input logic do_hold);
    exp_l = exp_l + 3'd1;
    if (exp_l == 3'(WIN_SCORE)) begin exp_go = 1'b1; exp_w = 1'b0; end
    step(1'b1, 1'b0, 1'b0, 1'b1, "l_point");
    if (do_hold && !exp_go) hold_phase();
  endtask

  task automatic right_point(input logic do_hold);
    exp_r = exp_r + 3'd1;
    if (exp_r == 3'(WIN_SCORE)) begin exp_go = 1'b1; exp_w = 1'b1; end
    step(1'b0, 1'b1, 1'b0, 1'b1, "r_point");
    if (do_hold && !exp_go) hold_phase();
  endtask

  task automatic clear_exp();
    exp_l = 3'd0; exp_r = 3'd0; exp_go = 1'b0; exp_w = 1'b0; exp_f = 1'b0;
  endtask

  initial begin
    reset = 1'b1; L = 1'b0; R = 1'b0;

    // reset masks presses, then one INIT cycle, then play from the centre
    step(1'b1, 1'b0, 1'b1, 1'b1, "reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, "init_to_play");
    chk("lights_center", lights, 10'(9'b000010000));
    idle($urandom_range(0, 2));

    // walk to the left edge, cancelled double press, then a left point
    walk_left();
    step(1'b1, 1'b1, 1'b0, 1'b0, "both_cancel");
    chk("both_light_unmoved", lights, 10'(9'b100000000));
    left_point(1'b1);

    // two more left points; reset lands in the middle of the third hold
    walk_left(); left_point(1'b1);
    idle($urandom_range(0, 2));
    walk_left(); left_point(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, "hold_mid");
    clear_exp();
    step(1'b1, 1'b0, 1'b1, 1'b1, "reset_mid_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, "replay_after_reset");

    // two lights lit during play: sticky fault, kept through a hold
    force_en = 1'b1; force_val = 9'b000011000; exp_f = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, "fault_set");
    force_en = 1'b0;
    idle(1);
    walk_left(); left_point(1'b1);
    clear_exp();
    step(1'b0, 1'b0, 1'b1, 1'b1, "fault_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, "fault_cleared_play");

    // right player takes the match; OVER ignores everything but reset
    for (int p = 0; p < WIN_SCORE; p++) begin
      walk_right();
      right_point(1'b1);
    end
    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, "over_locked");
    step(1'b0, 1'b1, 1'b0, 1'b1, "over_press_r");
    clear_exp();
    step(1'b0, 1'b0, 1'b1, 1'b1, "over_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, "over_replay");

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
